iter_divider: RTL and testbench

- Parametrised multi-cycle radix-2 restoring divider for the CPU execute stage, replacing the fixed 16-bit unsigned divider.
- Adds signed/unsigned mode, a defined divide-by-zero result, an abort input, a busy indication and a deterministic latency.
- Sits beside the ALU; the issue logic holds the op until done.

---
 rtl/iter_divider_if.sv | 26 ++
 rtl/iter_divider.sv | 135 +++++++++++++
 tb/tb_iter_divider.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/iter_divider_if.sv
// Request/response bundle between the execute-stage issue logic and the iterative divider.
// The issue side is the master; the divider is the slave.
interface iter_divider_if #(
    parameter int N = 16
);
    logic         req;
    logic         signed_mode;
    logic         abort;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         busy;
    logic         done;
    logic         div_by_zero;

    modport master (
        output req, signed_mode, abort, dividend, divisor,
        input  q, r, busy, done, div_by_zero
    );

    modport slave (
        input  req, signed_mode, abort, dividend, divisor,
        output q, r, busy, done, div_by_zero
    );
endinterface

// File: rtl/iter_divider.sv
// Multi-cycle radix-2 restoring divider with optional signed mode, abort and divide-by-zero handling.
// Operands are converted to magnitudes on accept; signs are reapplied in the FIX cycle.
module iter_divider #(
    parameter int N         = 16,
    parameter bit SIGNED_EN = 1'b1
) (
    input logic           clk,
    input logic           rstn,
    iter_divider_if.slave bus
);
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        ZERO
    } state_t;

    state_t state, next_state;

    logic [CW-1:0] count;
    logic [N-1:0]  part_rem;
    logic [N-1:0]  shift_reg;
    logic [N-1:0]  divisor_mag;
    logic          q_neg;
    logic          r_neg;

    logic          signed_op;
    logic          dividend_neg;
    logic          divisor_neg;
    logic [N-1:0]  dividend_mag_in;
    logic [N-1:0]  divisor_mag_in;
    logic          accept;
    logic          kill;
    logic          last_iter;
    logic [N:0]    shifted;
    logic [N:0]    trial;
    logic          trial_ok;
    logic [N-1:0]  q_fixed;
    logic [N-1:0]  r_fixed;
    logic [N-1:0]  r_zero;

    // shift_reg holds the dividend magnitude on accept; quotient bits enter at the LSB as
    // dividend bits leave the MSB, so after N iterations it holds the quotient magnitude.
    always_comb begin
        signed_op       = SIGNED_EN && bus.signed_mode;
        dividend_neg    = signed_op & bus.dividend[N-1];
        divisor_neg     = signed_op & bus.divisor[N-1];
        dividend_mag_in = dividend_neg ? -bus.dividend : bus.dividend;
        divisor_mag_in  = divisor_neg ? -bus.divisor : bus.divisor;
        accept          = (state == IDLE) && bus.req;
        kill            = bus.abort && (state != IDLE);
        last_iter       = (count == CW'(N - 1));
        shifted         = {part_rem, shift_reg[N-1]};
        trial           = shifted - {1'b0, divisor_mag};
        trial_ok        = ~trial[N];
        q_fixed         = q_neg ? -shift_reg : shift_reg;
        r_fixed         = r_neg ? -part_rem : part_rem;
        r_zero          = r_neg ? -shift_reg : shift_reg;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Abort overrides every transition, including the FIX/ZERO completion cycle.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    next_state = (bus.divisor == '0) ? ZERO : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = IDLE;
            ZERO:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
        if (kill) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            count           <= '0;
            part_rem        <= '0;
            shift_reg       <= '0;
            divisor_mag     <= '0;
            q_neg           <= 1'b0;
            r_neg           <= 1'b0;
            bus.q           <= '0;
            bus.r           <= '0;
            bus.done        <= 1'b0;
            bus.div_by_zero <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            if (accept) begin
                count           <= '0;
                part_rem        <= '0;
                shift_reg       <= dividend_mag_in;
                divisor_mag     <= divisor_mag_in;
                q_neg           <= dividend_neg ^ divisor_neg;
                r_neg           <= dividend_neg;
                bus.div_by_zero <= 1'b0;
            end else if ((state == CALC) && !kill) begin
                part_rem  <= trial_ok ? trial[N-1:0] : shifted[N-1:0];
                shift_reg <= {shift_reg[N-2:0], trial_ok};
                count     <= count + CW'(1);
            end else if ((state == FIX) && !kill) begin
                bus.q    <= q_fixed;
                bus.r    <= r_fixed;
                bus.done <= 1'b1;
            end else if ((state == ZERO) && !kill) begin
                bus.q           <= '1;
                bus.r           <= r_zero;
                bus.div_by_zero <= 1'b1;
                bus.done        <= 1'b1;
            end
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_iter_divider.sv
// Directed bench for iter_divider at N=16: hand-computed quotients/remainders, latency,
// divide-by-zero, overflow, abort (mid-CALC and in FIX), back-to-back requests and async reset.
module tb_iter_divider;
    localparam int N = 16;

    logic clk;
    logic rstn;
    int   passed;
    int   total;

    iter_divider_if #(.N(N)) bus ();

    iter_divider #(.N(N), .SIGNED_EN(1'b1)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b, input logic m);
        bus.dividend    = a;
        bus.divisor     = b;
        bus.signed_mode = m;
        bus.req         = 1'b1;
        step();
        bus.req = 1'b0;
    endtask

    // Called just after the accept edge; returns edges until done and busy-high samples.
    task automatic waitDone(input string tag, output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        while (!bus.done && lat < 64) begin
            if (bus.busy) busy_cnt++;
            step();
            lat++;
        end
        if (!bus.done) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic runOp(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic m, input logic [N-1:0] exp_q, input logic [N-1:0] exp_r,
                         input logic exp_dbz, input int exp_lat);
        int lat;
        int busy_cnt;
        applyStimulus(a, b, m);
        waitDone(tag, lat, busy_cnt);
        checkOutput({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        checkOutput({tag, "_busycnt"}, 32'(busy_cnt), 32'(exp_lat));
        checkOutput({tag, "_q"}, 32'(bus.q), 32'(exp_q));
        checkOutput({tag, "_r"}, 32'(bus.r), 32'(exp_r));
        checkOutput({tag, "_dbz"}, 32'(bus.div_by_zero), 32'(exp_dbz));
        step();
        checkOutput({tag, "_donepulse"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        int lat;
        int busy_cnt;
        logic saw_done;

        passed          = 0;
        total           = 0;
        rstn            = 1'b0;
        bus.req         = 1'b0;
        bus.signed_mode = 1'b0;
        bus.abort       = 1'b0;
        bus.dividend    = '0;
        bus.divisor     = '0;

        #22;
        checkOutput("rst_q", 32'(bus.q), 32'd0);
        checkOutput("rst_r", 32'(bus.r), 32'd0);
        checkOutput("rst_busy", 32'(bus.busy), 32'd0);
        checkOutput("rst_done", 32'(bus.done), 32'd0);
        checkOutput("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        rstn = 1'b1;
        step();

        runOp("u100_7", 16'd100, 16'd7, 1'b0, 16'd14, 16'd2, 1'b0, N + 1);
        runOp("sn100_7", 16'hFF9C, 16'd7, 1'b1, 16'hFFF2, 16'hFFFE, 1'b0, N + 1);
        runOp("s100_n7", 16'd100, 16'hFFF9, 1'b1, 16'hFFF2, 16'h0002, 1'b0, N + 1);
        runOp("sn100_n7", 16'hFF9C, 16'hFFF9, 1'b1, 16'd14, 16'hFFFE, 1'b0, N + 1);
        runOp("dbz_u", 16'h1234, 16'h0000, 1'b0, 16'hFFFF, 16'h1234, 1'b1, 1);
        runOp("dbz_s", 16'h8005, 16'h0000, 1'b1, 16'hFFFF, 16'h8005, 1'b1, 1);
        runOp("s_ovf", 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 16'h0000, 1'b0, N + 1);
        runOp("u_8000", 16'h8000, 16'hFFFF, 1'b0, 16'h0000, 16'h8000, 1'b0, N + 1);
        runOp("u_ffff_1", 16'hFFFF, 16'h0001, 1'b0, 16'hFFFF, 16'h0000, 1'b0, N + 1);

        // Abort in the fifth CALC cycle: result registers keep 0xFFFF / 0.
        applyStimulus(16'd1000, 16'd3, 1'b0);
        repeat (4) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checkOutput("abort_busy", 32'(bus.busy), 32'd0);
        checkOutput("abort_done", 32'(bus.done), 32'd0);
        checkOutput("abort_q", 32'(bus.q), 32'h0000FFFF);
        checkOutput("abort_r", 32'(bus.r), 32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            step();
            if (bus.done) saw_done = 1'b1;
        end
        checkOutput("abort_nodone", 32'(saw_done), 32'd0);
        runOp("after_abort", 16'd1000, 16'd3, 1'b0, 16'd333, 16'd1, 1'b0, N + 1);

        // Abort coinciding with the FIX cycle: no done, q/r keep 333 / 1.
        applyStimulus(16'd200, 16'd9, 1'b0);
        repeat (N) step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        checkOutput("abortfix_done", 32'(bus.done), 32'd0);
        checkOutput("abortfix_busy", 32'(bus.busy), 32'd0);
        checkOutput("abortfix_q", 32'(bus.q), 32'd333);
        checkOutput("abortfix_r", 32'(bus.r), 32'd1);

        // req held high: operand changes while busy are ignored; re-accept one edge after done.
        bus.dividend    = 16'd50;
        bus.divisor     = 16'd5;
        bus.signed_mode = 1'b0;
        bus.req         = 1'b1;
        step();
        bus.dividend = 16'd999;
        waitDone("b2b1", lat, busy_cnt);
        checkOutput("b2b1_lat", 32'(lat), 32'(N + 1));
        checkOutput("b2b1_q", 32'(bus.q), 32'd10);
        checkOutput("b2b1_r", 32'(bus.r), 32'd0);
        checkOutput("b2b1_busy_at_done", 32'(bus.busy), 32'd0);
        bus.dividend = 16'd77;
        step();
        bus.req = 1'b0;
        checkOutput("b2b2_accept_busy", 32'(bus.busy), 32'd1);
        checkOutput("b2b2_accept_done", 32'(bus.done), 32'd0);
        waitDone("b2b2", lat, busy_cnt);
        checkOutput("b2b2_lat", 32'(lat), 32'(N + 1));
        checkOutput("b2b2_q", 32'(bus.q), 32'd15);
        checkOutput("b2b2_r", 32'(bus.r), 32'd2);
        step();

        // Async reset mid-CALC clears outputs without waiting for a clock edge.
        applyStimulus(16'd5000, 16'd7, 1'b0);
        repeat (3) step();
        #2;
        rstn = 1'b0;
        #1;
        checkOutput("midrst_q", 32'(bus.q), 32'd0);
        checkOutput("midrst_r", 32'(bus.r), 32'd0);
        checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
        checkOutput("midrst_done", 32'(bus.done), 32'd0);
        checkOutput("midrst_dbz", 32'(bus.div_by_zero), 32'd0);
        #3;
        rstn = 1'b1;
        step();
        checkOutput("postrst_busy", 32'(bus.busy), 32'd0);
        runOp("postrst", 16'd5000, 16'd7, 1'b0, 16'd714, 16'd2, 1'b0, N + 1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
